// File: rtl/note_sequencer.sv
// Note list store and timed playback streamer sitting behind the composer controller.
// Notes are appended/removed while idle and streamed out, one NOTE_TICKS slot each, on play.
module note_sequencer #(
    parameter int DEPTH      = 16,
    parameter int NOTE_W     = 4,
    parameter int NOTE_TICKS = 12500000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       insert_en,
    input  logic                       delete_en,
    input  logic                       clear_en,
    input  logic                       play_en,
    input  logic [NOTE_W-1:0]          note_in,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       is_full,
    output logic                       is_empty,
    output logic                       busy,
    output logic [NOTE_W-1:0]          note_out,
    output logic                       note_valid,
    output logic [$clog2(DEPTH)-1:0]   play_idx,
    output logic                       play_done
);

    // state | meaning
    // IDLE  | list editable, waiting for an armed play request
    // PLAY  | streaming stored notes, edits ignored, count frozen
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TICK_W = $clog2(NOTE_TICKS);

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [NOTE_W-1:0]   mem [DEPTH];
    logic [TICK_W-1:0]   tick;
    logic                armed;
    logic                start;
    logic                edit_ok;
    logic                do_insert;
    logic                last_tick;
    logic                last_note;
    logic [IDX_W-1:0]    next_idx;

    assign start     = (state == IDLE) && play_en && armed;
    assign edit_ok   = (state == IDLE) && !start;
    assign do_insert = edit_ok && !clear_en && !delete_en && insert_en && !is_full;
    assign last_tick = (tick == TICK_W'(NOTE_TICKS - 1));
    assign last_note = (CNT_W'(play_idx) == count - CNT_W'(1));
    assign next_idx  = play_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && count != '0) state_nxt = PLAY;
            PLAY: if (last_tick && last_note) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == PLAY);
        is_full  = (count == CNT_W'(DEPTH));
        is_empty = (count == '0);
    end

    // Storage is deliberately not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_insert) mem[IDX_W'(count)] <= note_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            play_idx   <= '0;
            tick       <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            play_done  <= 1'b0;
            armed      <= 1'b1;
        end else begin
            play_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        armed <= 1'b0;
                        if (count != '0) begin
                            play_idx   <= '0;
                            tick       <= '0;
                            note_out   <= mem[0];
                            note_valid <= 1'b1;
                        end else begin
                            play_done <= 1'b1;
                        end
                    end else begin
                        // Re-arm only once the controller has dropped its request.
                        if (!play_en) armed <= 1'b1;
                        if (clear_en)                       count <= '0;
                        else if (delete_en && !is_empty)    count <= count - CNT_W'(1);
                        else if (do_insert)                 count <= count + CNT_W'(1);
                    end
                end
                PLAY: begin
                    if (last_tick) begin
                        tick <= '0;
                        if (last_note) begin
                            note_valid <= 1'b0;
                            note_out   <= '0;
                            play_done  <= 1'b1;
                            play_idx   <= '0;
                        end else begin
                            play_idx <= next_idx;
                            note_out <= mem[next_idx];
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with DEPTH=4, NOTE_TICKS=3: vector table for
// edit/priority/empty-play behaviour, hand sequences for playback, re-arm and reset abort.
module tb_note_sequencer;

    localparam int DEPTH      = 4;
    localparam int NOTE_W     = 4;
    localparam int NOTE_TICKS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        insert_en, delete_en, clear_en, play_en;
    logic [3:0]  note_in;
    logic [2:0]  count;
    logic        is_full, is_empty, busy;
    logic [3:0]  note_out;
    logic        note_valid;
    logic [1:0]  play_idx;
    logic        play_done;

    int n_pass  = 0;
    int n_total = 0;

    note_sequencer #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .NOTE_TICKS(NOTE_TICKS)) dut (
        .clk(clk), .reset(reset),
        .insert_en(insert_en), .delete_en(delete_en), .clear_en(clear_en), .play_en(play_en),
        .note_in(note_in), .count(count), .is_full(is_full), .is_empty(is_empty), .busy(busy),
        .note_out(note_out), .note_valid(note_valid), .play_idx(play_idx), .play_done(play_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ins, del, clr, ply;
        logic [3:0] nin;
        int         cnt;
        logic       full, empty, busy;
        logic [3:0] nout;
        logic       vld, done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic i, input logic d, input logic c,
                         input logic p, input logic [3:0] n);
        reset = r; insert_en = i; delete_en = d; clear_en = c; play_en = p; note_in = n;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int cnt, input logic full, input logic empty,
                           input logic bsy, input logic [3:0] nout, input logic vld,
                           input logic done);
        chk({tag, "_count"},    32'(count),      32'(cnt));
        chk({tag, "_is_full"},  32'(is_full),    32'(full));
        chk({tag, "_is_empty"}, 32'(is_empty),   32'(empty));
        chk({tag, "_busy"},     32'(busy),       32'(bsy));
        chk({tag, "_note_out"}, 32'(note_out),   32'(nout));
        chk({tag, "_valid"},    32'(note_valid), 32'(vld));
        chk({tag, "_done"},     32'(play_done),  32'(done));
    endtask

    // Streams {7,2,9}; optionally pulses edit ops mid-play, which must have no effect.
    task automatic run_playback(input string tag, input bit edits);
        logic [3:0] notes [3];
        notes[0] = 4'd7; notes[1] = 4'd2; notes[2] = 4'd9;
        for (int i = 0; i < 9; i++) begin
            if (edits) begin
                insert_en = (i == 1 || i == 2);
                delete_en = (i == 4);
                clear_en  = (i == 6);
                note_in   = 4'hF;
            end
            step();
            chk_all($sformatf("%s_n%0d", tag, i), 3, 1'b0, 1'b0, 1'b1, notes[i/3], 1'b1, 1'b0);
            chk($sformatf("%s_n%0d_idx", tag, i), 32'(play_idx), 32'(i/3));
        end
        insert_en = 1'b0; delete_en = 1'b0; clear_en = 1'b0;
        step();
        chk_all({tag, "_end"}, 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        chk({tag, "_end_idx"}, 32'(play_idx), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        //            rst ins del clr ply nin  cnt full empty busy nout vld done
        vecs.push_back('{1, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd1, 1, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd2, 2, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd3, 3, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd4, 4, 1, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd5, 4, 1, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 4'd0, 3, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd1, 1, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd2, 2, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 4'd3, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd3, 1, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd4, 2, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 4'd5, 1, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd7, 1, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd2, 2, 0, 0, 0, 4'd0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4'd9, 3, 0, 0, 0, 4'd0, 0, 0});

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].ins, vecs[k].del, vecs[k].clr, vecs[k].ply, vecs[k].nin);
            step();
            chk_all($sformatf("v%0d", k), vecs[k].cnt, vecs[k].full, vecs[k].empty,
                    vecs[k].busy, vecs[k].nout, vecs[k].vld, vecs[k].done);
        end

        // Playback of {7,2,9}, then play_en held high must not retrigger.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        run_playback("play", 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("hold%0d", i), 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // One low cycle re-arms; restart with edit pulses that must be ignored.
        play_en = 1'b0;
        step();
        chk_all("rearm", 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        play_en = 1'b1;
        run_playback("edit", 1'b1);
        play_en = 1'b0;
        step();
        chk_all("post_edit", 3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset during the second note aborts without a done pulse.
        play_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mid_note", 32'(note_out), 32'd2);
        chk("mid_busy", 32'(busy), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step();
        chk_all("rst_abort", 0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        chk("rst_abort_idx", 32'(play_idx), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("after_rst%0d", i), 0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
